// File: rtl/tl_xing_a_arbiter.sv
// Merges N TileLink-UL requesters onto one A/D link: round-robin A arbitration locked over
// multi-beat Puts, requester index prepended to the source, D routed back by that index.
module tl_xing_a_arbiter #(
  parameter int  N_REQ      = 2,
  parameter int  SRC_W      = 4,
  parameter int  DATA_BYTES = 8,
  parameter int  MAX_INFL   = 4,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [N_REQ-1:0]                req_a_valid,
  output logic [N_REQ-1:0]                req_a_ready,
  input  logic [3*N_REQ-1:0]              req_a_opcode,
  input  logic [3*N_REQ-1:0]              req_a_size,
  input  logic [SRC_W*N_REQ-1:0]          req_a_source,
  input  logic [25*N_REQ-1:0]             req_a_address,
  input  logic [8*DATA_BYTES*N_REQ-1:0]   req_a_data,
  input  logic [DATA_BYTES*N_REQ-1:0]     req_a_mask,
  output logic                            xing_a_valid,
  input  logic                            xing_a_ready,
  output logic [2:0]                      xing_a_opcode,
  output logic [2:0]                      xing_a_size,
  output logic [SRC_W+IDX_W-1:0]          xing_a_source,
  output logic [24:0]                     xing_a_address,
  output logic [8*DATA_BYTES-1:0]         xing_a_data,
  output logic [DATA_BYTES-1:0]           xing_a_mask,
  input  logic                            xing_d_valid,
  output logic                            xing_d_ready,
  input  logic [2:0]                      xing_d_opcode,
  input  logic [2:0]                      xing_d_size,
  input  logic [SRC_W+IDX_W-1:0]          xing_d_source,
  input  logic [8*DATA_BYTES-1:0]         xing_d_data,
  output logic [N_REQ-1:0]                req_d_valid,
  input  logic [N_REQ-1:0]                req_d_ready,
  output logic [2:0]                      req_d_opcode,
  output logic [2:0]                      req_d_size,
  output logic [SRC_W-1:0]                req_d_source,
  output logic [8*DATA_BYTES-1:0]         req_d_data
);

  localparam int LGB = $clog2(DATA_BYTES);
  localparam int DW  = 8 * DATA_BYTES;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, r_grant;
  logic [7:0]       r_beats, r_dbeats;
  logic [3:0]       r_infl [N_REQ];

  logic [2:0]       w_op   [N_REQ];
  logic [2:0]       w_sz   [N_REQ];
  logic [SRC_W-1:0] w_src  [N_REQ];
  logic [24:0]      w_addr [N_REQ];
  logic [DW-1:0]    w_data [N_REQ];
  logic [DATA_BYTES-1:0] w_mask [N_REQ];
  logic [N_REQ-1:0] w_elig, w_inc, w_dec;

  logic [IDX_W-1:0] w_g, w_g_arb, w_j, w_ptr_nxt, w_d_idx;
  logic             w_found, w_sel_vld, w_a_fire, w_a_first, w_a_done, w_a_put;
  logic [7:0]       w_a_beats, w_d_beats;
  logic             w_d_in, w_d_fire, w_d_last;

  // Beats in a message: only data-carrying messages wider than one beat span several.
  function automatic logic [7:0] f_beats(input logic [2:0] size, input logic has_data);
    if (has_data && int'(size) > LGB) f_beats = 8'(1 << (int'(size) - LGB));
    else                              f_beats = 8'd1;
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_op[gi]   = req_a_opcode[3*gi +: 3];
    assign w_sz[gi]   = req_a_size[3*gi +: 3];
    assign w_src[gi]  = req_a_source[SRC_W*gi +: SRC_W];
    assign w_addr[gi] = req_a_address[25*gi +: 25];
    assign w_data[gi] = req_a_data[DW*gi +: DW];
    assign w_mask[gi] = req_a_mask[DATA_BYTES*gi +: DATA_BYTES];
    assign w_elig[gi] = req_a_valid[gi] && (r_infl[gi] < 4'(MAX_INFL));
  end

  always_comb begin
    w_g_arb = r_ptr;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = IDX_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && w_elig[w_j]) begin
        w_found = 1'b1;
        w_g_arb = w_j;
      end
    end
  end

  // A burst holds the grant regardless of eligibility; valid outputs stay low in reset.
  assign w_g            = (r_state == S_BURST) ? r_grant : w_g_arb;
  assign w_sel_vld      = (r_state == S_BURST) ? req_a_valid[r_grant] : w_found;
  assign xing_a_valid   = reset_n && w_sel_vld;
  assign xing_a_opcode  = w_op[w_g];
  assign xing_a_size    = w_sz[w_g];
  assign xing_a_source  = {w_g, w_src[w_g]};
  assign xing_a_address = w_addr[w_g];
  assign xing_a_data    = w_data[w_g];
  assign xing_a_mask    = w_mask[w_g];

  always_comb begin
    req_a_ready = '0;
    if (xing_a_valid) req_a_ready[w_g] = xing_a_ready;
  end

  assign w_a_put   = (xing_a_opcode == 3'd0) || (xing_a_opcode == 3'd1);
  assign w_a_beats = f_beats(xing_a_size, w_a_put);
  assign w_a_fire  = xing_a_valid && xing_a_ready;
  assign w_a_first = w_a_fire && (r_state == S_IDLE);
  assign w_a_done  = w_a_fire && ((r_state == S_IDLE) ? (w_a_beats == 8'd1) : (r_beats == 8'd1));
  assign w_ptr_nxt = (w_g == IDX_W'(N_REQ - 1)) ? '0 : w_g + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_a_first && w_a_beats != 8'd1) w_state_nxt = S_BURST;
      S_BURST: if (w_a_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_beats <= '0;
    end else begin
      if (w_a_done) r_ptr <= w_ptr_nxt;
      if (w_a_first && w_a_beats != 8'd1) begin
        r_grant <= w_g;
        r_beats <= w_a_beats - 8'd1;
      end else if (w_a_fire && r_state == S_BURST) begin
        r_beats <= r_beats - 8'd1;
      end
    end
  end

  // D path: routed purely by the source tag, independent of A-side state.
  assign w_d_idx      = xing_d_source[SRC_W +: IDX_W];
  assign w_d_in       = int'(w_d_idx) < N_REQ;
  assign req_d_opcode = xing_d_opcode;
  assign req_d_size   = xing_d_size;
  assign req_d_source = xing_d_source[SRC_W-1:0];
  assign req_d_data   = xing_d_data;

  always_comb begin
    req_d_valid  = '0;
    xing_d_ready = 1'b1;
    if (w_d_in) begin
      req_d_valid[w_d_idx] = xing_d_valid && reset_n;
      xing_d_ready         = req_d_ready[w_d_idx];
    end
  end

  assign w_d_fire  = xing_d_valid && xing_d_ready;
  assign w_d_beats = f_beats(xing_d_size, xing_d_opcode == 3'd1);
  assign w_d_last  = w_d_fire && ((r_dbeats == 8'd0) ? (w_d_beats == 8'd1) : (r_dbeats == 8'd1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        r_dbeats <= '0;
    else if (w_d_fire && r_dbeats == '0) r_dbeats <= w_d_beats - 8'd1;
    else if (w_d_fire)                   r_dbeats <= r_dbeats - 8'd1;
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_inc[i] = w_a_first && (w_g == IDX_W'(i));
      w_dec[i] = w_d_last && w_d_in && (w_d_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) r_infl[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_inc[i] && !w_dec[i] && r_infl[i] != 4'hF)      r_infl[i] <= r_infl[i] + 4'd1;
        else if (w_dec[i] && !w_inc[i] && r_infl[i] != 4'd0) r_infl[i] <= r_infl[i] - 4'd1;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chk
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(w_dec[gi] && !w_inc[gi] && r_infl[gi] == 4'd0));
  end

endmodule

// File: tb/tb_tl_xing_a_arbiter.sv
// Directed bench for tl_xing_a_arbiter (N_REQ=2, SRC_W=4, DATA_BYTES=8, MAX_INFL=4).
module tb_tl_xing_a_arbiter;

  localparam logic [2:0] GET = 3'd4, PF = 3'd0, AK = 3'd0, AD = 3'd1;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF, D1 = 64'hFEDC_BA98_7654_3210;

  logic         clock = 1'b0, reset_n;
  logic [1:0]   req_a_valid, req_a_ready;
  logic [5:0]   req_a_opcode, req_a_size;
  logic [7:0]   req_a_source;
  logic [49:0]  req_a_address;
  logic [127:0] req_a_data;
  logic [15:0]  req_a_mask;
  logic         xing_a_valid, xing_a_ready;
  logic [2:0]   xing_a_opcode, xing_a_size;
  logic [4:0]   xing_a_source;
  logic [24:0]  xing_a_address;
  logic [63:0]  xing_a_data;
  logic [7:0]   xing_a_mask;
  logic         xing_d_valid, xing_d_ready;
  logic [2:0]   xing_d_opcode, xing_d_size;
  logic [4:0]   xing_d_source;
  logic [63:0]  xing_d_data;
  logic [1:0]   req_d_valid, req_d_ready;
  logic [2:0]   req_d_opcode, req_d_size;
  logic [3:0]   req_d_source;
  logic [63:0]  req_d_data;

  int n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  tl_xing_a_arbiter #(.N_REQ(2), .SRC_W(4), .DATA_BYTES(8), .MAX_INFL(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_opcode(req_a_opcode),
    .req_a_size(req_a_size), .req_a_source(req_a_source), .req_a_address(req_a_address),
    .req_a_data(req_a_data), .req_a_mask(req_a_mask),
    .xing_a_valid(xing_a_valid), .xing_a_ready(xing_a_ready), .xing_a_opcode(xing_a_opcode),
    .xing_a_size(xing_a_size), .xing_a_source(xing_a_source), .xing_a_address(xing_a_address),
    .xing_a_data(xing_a_data), .xing_a_mask(xing_a_mask),
    .xing_d_valid(xing_d_valid), .xing_d_ready(xing_d_ready), .xing_d_opcode(xing_d_opcode),
    .xing_d_size(xing_d_size), .xing_d_source(xing_d_source), .xing_d_data(xing_d_data),
    .req_d_valid(req_d_valid), .req_d_ready(req_d_ready), .req_d_opcode(req_d_opcode),
    .req_d_size(req_d_size), .req_d_source(req_d_source), .req_d_data(req_d_data)
  );

  typedef struct {
    string      nm;
    logic [1:0] av;
    logic [2:0] op0, sz0, op1, sz1;
    logic       xar, dv;
    logic [2:0] dop, dsz;
    logic [4:0] dsrc;
    logic [1:0] drdy;
    logic       e_xav, e_g;
    logic [1:0] e_arq, e_dv;
    logic       e_drdy;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [1:0] av,
                              input logic [2:0] op0, sz0, op1, sz1, input logic xar, dv,
                              input logic [2:0] dop, dsz, input logic [4:0] dsrc,
                              input logic [1:0] drdy, input logic e_xav, e_g,
                              input logic [1:0] e_arq, e_dv, input logic e_drdy);
    vec_t v;
    v.nm = nm; v.av = av; v.op0 = op0; v.sz0 = sz0; v.op1 = op1; v.sz1 = sz1;
    v.xar = xar; v.dv = dv; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc; v.drdy = drdy;
    v.e_xav = e_xav; v.e_g = e_g; v.e_arq = e_arq; v.e_dv = e_dv; v.e_drdy = e_drdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    req_a_valid   = v.av;
    req_a_opcode  = {v.op1, v.op0};
    req_a_size    = {v.sz1, v.sz0};
    xing_a_ready  = v.xar;
    xing_d_valid  = v.dv;
    xing_d_opcode = v.dop;
    xing_d_size   = v.dsz;
    xing_d_source = v.dsrc;
    req_d_ready   = v.drdy;
    @(negedge clock);
    chk({v.nm, ".xa_valid"}, 64'(xing_a_valid), 64'(v.e_xav));
    chk({v.nm, ".a_ready"}, 64'(req_a_ready), 64'(v.e_arq));
    chk({v.nm, ".d_valid"}, 64'(req_d_valid), 64'(v.e_dv));
    chk({v.nm, ".xd_ready"}, 64'(xing_d_ready), 64'(v.e_drdy));
    if (v.e_xav) begin
      chk({v.nm, ".xa_source"}, 64'(xing_a_source), v.e_g ? 64'h1A : 64'h03);
      chk({v.nm, ".xa_data"}, xing_a_data, v.e_g ? D1 : D0);
    end
    if (v.dv) chk({v.nm, ".d_source"}, 64'(req_d_source), 64'(v.dsrc[3:0]));
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // Bursts, arbitration order and D routing, executed back to back.
    tbl.push_back(mk("t1_g0",  2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t1_g1",  2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    tbl.push_back(mk("t1_g0b", 2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t1_g1b", 2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    tbl.push_back(mk("d_ack0", 2'b00, GET,0, GET,0, 1, 1,AK,0,5'h03,2'b11, 0,0,2'b00,2'b01,1));
    tbl.push_back(mk("d_ack1", 2'b00, GET,0, GET,0, 1, 1,AK,0,5'h13,2'b11, 0,0,2'b00,2'b10,1));
    tbl.push_back(mk("d_ack0b",2'b00, GET,0, GET,0, 1, 1,AK,0,5'h03,2'b11, 0,0,2'b00,2'b01,1));
    tbl.push_back(mk("d_ack1b",2'b00, GET,0, GET,0, 1, 1,AK,0,5'h13,2'b11, 0,0,2'b00,2'b10,1));
    tbl.push_back(mk("d_bp",   2'b00, GET,0, GET,0, 1, 1,AK,0,5'h13,2'b01, 0,0,2'b00,2'b10,0));
    tbl.push_back(mk("t2_b0",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t2_b1",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t2_b2",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t2_b3",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t2_r1",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    tbl.push_back(mk("t3_b0",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t3_s0",  2'b11, PF,5,  GET,0, 0, 0,AK,0,5'h00,2'b11, 1,0,2'b00,2'b00,1));
    tbl.push_back(mk("t3_s1",  2'b11, PF,5,  GET,0, 0, 0,AK,0,5'h00,2'b11, 1,0,2'b00,2'b00,1));
    tbl.push_back(mk("t3_s2",  2'b11, PF,5,  GET,0, 0, 0,AK,0,5'h00,2'b11, 1,0,2'b00,2'b00,1));
    tbl.push_back(mk("t3_b1",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t3_b2",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t3_b3",  2'b11, PF,5,  GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    tbl.push_back(mk("t3_ptr", 2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("t5_d",  2'b00, GET,0, GET,0, 1, 1,AD,5,5'h13,2'b11, 0,0,2'b00,2'b10,1));
    tbl.push_back(mk("d_ack0c",2'b00, GET,0, GET,0, 1, 1,AK,0,5'h03,2'b11, 0,0,2'b00,2'b01,1));
    tbl.push_back(mk("d_ack0d",2'b00, GET,0, GET,0, 1, 1,AK,0,5'h03,2'b11, 0,0,2'b00,2'b01,1));
    tbl.push_back(mk("d_ack1c",2'b00, GET,0, GET,0, 1, 1,AK,0,5'h13,2'b11, 0,0,2'b00,2'b10,1));

    req_a_source  = {4'hA, 4'h3};
    req_a_address = {25'h0000200, 25'h0000100};
    req_a_data    = {D1, D0};
    req_a_mask    = 16'hF0FF;
    xing_d_data   = 64'h5555_AAAA_5555_AAAA;
    reset_n       = 1'b0;
    req_a_valid   = 2'b11;
    req_a_opcode  = {GET, GET};
    req_a_size    = '0;
    xing_a_ready  = 1'b1;
    xing_d_valid  = 1'b1;
    xing_d_opcode = AK;
    xing_d_size   = '0;
    xing_d_source = 5'h13;
    req_d_ready   = 2'b11;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.xa_valid", 64'(xing_a_valid), 64'd0);
    chk("rst.a_ready", 64'(req_a_ready), 64'd0);
    chk("rst.d_valid", 64'(req_d_valid), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Inflight cap on req0, with req1 taking over while req0 is blocked.
    for (int i = 0; i < 4; i++)
      apply(mk("t4_fill", 2'b01, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    apply(mk("t4_cap",   2'b01, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 0,0,2'b00,2'b00,1));
    apply(mk("t4_r1a",   2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    apply(mk("t4_r1b",   2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    apply(mk("t4_ackd",  2'b01, GET,0, GET,0, 1, 1,AD,3,5'h03,2'b11, 0,0,2'b00,2'b01,1));
    apply(mk("t4_reen",  2'b01, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    // Same-cycle A first beat and D last beat on req0 leave its count alone.
    apply(mk("t6_ack",   2'b00, GET,0, GET,0, 1, 1,AK,0,5'h03,2'b11, 0,0,2'b00,2'b01,1));
    apply(mk("t6_both",  2'b01, GET,0, GET,0, 1, 1,AK,0,5'h03,2'b11, 1,0,2'b01,2'b01,1));
    apply(mk("t6_last",  2'b01, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    apply(mk("t6_full",  2'b01, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 0,0,2'b00,2'b00,1));
    // Multi-beat AccessAckData releases req1 only after its final beat.
    apply(mk("t5_f1",    2'b10, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    apply(mk("t5_f2",    2'b10, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    apply(mk("t5_cap",   2'b10, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 0,0,2'b00,2'b00,1));
    for (int i = 0; i < 4; i++)
      apply(mk("t5_beat", 2'b10, GET,0, GET,0, 1, 1,AD,5,5'h13,2'b11, 0,0,2'b00,2'b10,1));
    apply(mk("t5_reen",  2'b10, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    apply(mk("t7_ack1",  2'b00, GET,0, GET,0, 1, 1,AK,0,5'h13,2'b11, 0,0,2'b00,2'b10,1));
    apply(mk("t7_b0",    2'b10, GET,0, PF,5,  1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));
    apply(mk("t7_b1",    2'b10, GET,0, PF,5,  1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));

    // Reset in the middle of req1's burst.
    reset_n       = 1'b0;
    req_a_valid   = 2'b11;
    req_a_opcode  = {GET, GET};
    xing_d_valid  = 1'b1;
    xing_d_source = 5'h13;
    @(negedge clock);
    chk("rst2.xa_valid", 64'(xing_a_valid), 64'd0);
    chk("rst2.a_ready", 64'(req_a_ready), 64'd0);
    chk("rst2.d_valid", 64'(req_d_valid), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    apply(mk("r_g0",     2'b11, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,0,2'b01,2'b00,1));
    apply(mk("r_g1",     2'b10, GET,0, GET,0, 1, 0,AK,0,5'h00,2'b11, 1,1,2'b10,2'b00,1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
